// File: rtl/onehot_demux.sv
// One-hot steered demux: one valid/ready input fanned out to CHANNELS registered slots.
// Define ONEHOT_DEMUX_CHECK_EN to drop non-one-hot beats and flag them on o_err.
module onehot_demux #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [CHANNELS-1:0]       i_onehot,
    input  logic [WIDTH-1:0]          i_data,
    output logic [CHANNELS-1:0]       o_valid,
    input  logic [CHANNELS-1:0]       o_ready,
    output logic [CHANNELS*WIDTH-1:0] o_data
`ifdef ONEHOT_DEMUX_CHECK_EN
    ,
    output logic                      o_err
`endif
);

    logic [CHANNELS-1:0]            full_q, full_d;
    logic [CHANNELS-1:0][WIDTH-1:0] slot_q, slot_d;
    logic [CHANNELS-1:0]            can_take;
    logic [CHANNELS-1:0]            load;
    logic                           fits;
    logic                           legal;
    logic                           accept;

    assign can_take = ~full_q | o_ready;
    assign fits     = &(~i_onehot | can_take);

`ifdef ONEHOT_DEMUX_CHECK_EN
    logic err_q, err_d;

    assign legal   = ($countones(i_onehot) == 1);
    // Illegal selects are swallowed so a bad producer cannot wedge the stream.
    assign i_ready = legal ? fits : 1'b1;
    assign err_d   = err_q | (i_valid & ~legal);
    assign o_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign legal   = |i_onehot;
    assign i_ready = legal & fits;
`endif

    assign accept = i_valid & i_ready & legal;
    assign load   = accept ? i_onehot : '0;

    always_comb begin
        full_d = full_q;
        slot_d = slot_q;
        for (int i = 0; i < CHANNELS; i++) begin
            // A draining slot may be refilled on the same edge.
            full_d[i] = load[i] | (full_q[i] & ~o_ready[i]);
            if (load[i]) begin
                slot_d[i] = i_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            slot_q <= '0;
        end else begin
            full_q <= full_d;
            slot_q <= slot_d;
        end
    end

    assign o_valid = full_q;
    assign o_data  = slot_q;

endmodule

// File: tb/tb_onehot_demux.sv
// Scoreboard bench for onehot_demux (2 channels, 8-bit data).
// Works with or without ONEHOT_DEMUX_CHECK_EN defined.
module tb_onehot_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [1:0]  i_onehot;
    logic [7:0]  i_data;
    logic [1:0]  o_valid;
    logic [1:0]  o_ready;
    logic [15:0] o_data;
`ifdef ONEHOT_DEMUX_CHECK_EN
    logic        o_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] q[2][$];

    onehot_demux #(.CHANNELS(2), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_onehot (i_onehot),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data)
`ifdef ONEHOT_DEMUX_CHECK_EN
        ,
        .o_err    (o_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [1:0] s);
`ifdef ONEHOT_DEMUX_CHECK_EN
        return (s == 2'b01) || (s == 2'b10);
`else
        return s != 2'b00;
`endif
    endfunction

    function automatic logic exp_ready();
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < 2; c++)
            if (i_onehot[c] && q[c].size() != 0 && !o_ready[c]) ok = 1'b0;
`ifdef ONEHOT_DEMUX_CHECK_EN
        if (!is_legal(i_onehot)) return 1'b1;
`else
        if (i_onehot == 2'b00) return 1'b0;
`endif
        return ok;
    endfunction

    // Mid-cycle: compare outputs, pop consumed beats, push accepted beats.
    task automatic tick();
        logic rdy;
        logic [7:0] e;
        #3;
        if (!rst) begin
            rdy = exp_ready();
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("o_valid[%0d]", c), 32'(o_valid[c]),
                    32'(q[c].size() != 0));
                if (o_valid[c] && o_ready[c] && q[c].size() != 0) begin
                    e = q[c].pop_front();
                    chk($sformatf("data_ch%0d", c), 32'(o_data[c*8 +: 8]),
                        32'(e));
                end
            end
            chk("i_ready", 32'(i_ready), 32'(rdy));
            if (i_valid && i_ready && is_legal(i_onehot))
                for (int c = 0; c < 2; c++)
                    if (i_onehot[c]) q[c].push_back(i_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b1;
        i_onehot = 2'b10;
        i_data = 8'hA5;
        o_ready = 2'b00;

        // Reset with a beat offered: nothing may land.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'h0);
        chk("rst_o_data", 32'(o_data), 32'h0);
`ifdef ONEHOT_DEMUX_CHECK_EN
        chk("rst_o_err", 32'(o_err), 32'h0);
`endif
        rst = 1'b0;
        tick();
        chk("first_valid", 32'(o_valid), 32'h2);
        chk("first_data", 32'(o_data[15:8]), 32'hA5);
        i_valid = 1'b0;
        o_ready = 2'b10;
        tick();

        // Stalled channel 0 blocks only its own beats.
        i_valid = 1'b1;
        i_onehot = 2'b01;
        i_data = 8'h11;
        tick();
        i_data = 8'h22;
        #1;
        chk("stall_ready", 32'(i_ready), 32'h0);
        tick();
        chk("stall_hold", 32'(o_data[7:0]), 32'h11);
        i_onehot = 2'b10;
        i_data = 8'h33;
        #1;
        chk("bypass_ready", 32'(i_ready), 32'h1);
        tick();

        // Drain and refill channel 0 on the same edge.
        o_ready = 2'b11;
        i_onehot = 2'b01;
        i_data = 8'h3C;
        #1;
        chk("refill_ready", 32'(i_ready), 32'h1);
        tick();
        chk("refill_valid", 32'(o_valid[0]), 32'h1);
        chk("refill_data", 32'(o_data[7:0]), 32'h3C);
        i_valid = 1'b0;
        repeat (2) tick();

        // 16 back-to-back beats, alternating channels.
        i_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_onehot = k[0] ? 2'b10 : 2'b01;
            i_data = 8'(k * 7 + 1);
            #1;
            chk("stream_ready", 32'(i_ready), 32'h1);
            tick();
        end
        i_valid = 1'b0;
        repeat (2) tick();

        // Non-one-hot selects.
        o_ready = 2'b00;
`ifdef ONEHOT_DEMUX_CHECK_EN
        i_valid = 1'b1;
        i_onehot = 2'b01;
        i_data = 8'h77;
        tick();
        i_onehot = 2'b11;
        i_data = 8'h88;
        #1;
        chk("multi_ready", 32'(i_ready), 32'h1);
        tick();
        i_onehot = 2'b00;
        #1;
        chk("zero_ready", 32'(i_ready), 32'h1);
        tick();
        i_valid = 1'b0;
        chk("drop_valid", 32'(o_valid), 32'h1);
        chk("drop_data", 32'(o_data[7:0]), 32'h77);
        chk("err_set", 32'(o_err), 32'h1);
        repeat (3) tick();
        chk("err_sticky", 32'(o_err), 32'h1);
`else
        i_valid = 1'b1;
        i_onehot = 2'b11;
        i_data = 8'h5A;
        tick();
        chk("bcast_valid", 32'(o_valid), 32'h3);
        chk("bcast_data", 32'(o_data), 32'h5A5A);
        i_onehot = 2'b00;
        #1;
        chk("zero_ready", 32'(i_ready), 32'h0);
        tick();
        i_valid = 1'b0;
`endif
        o_ready = 2'b11;
        repeat (2) tick();

        // Random traffic against the scoreboard.
        for (int k = 0; k < 300; k++) begin
            o_ready = 2'($urandom);
            i_valid = ($urandom_range(0, 3) != 0);
            i_onehot = 2'($urandom);
            i_data = 8'($urandom);
            tick();
        end
        i_valid = 1'b0;
        o_ready = 2'b11;
        repeat (2) tick();
        chk("drained0", 32'(q[0].size()), 32'h0);
        chk("drained1", 32'(q[1].size()), 32'h0);

        // Asynchronous reset with both slots full.
        o_ready = 2'b00;
        i_valid = 1'b1;
        i_onehot = 2'b01;
        i_data = 8'h01;
        tick();
        i_onehot = 2'b10;
        i_data = 8'h02;
        tick();
        i_valid = 1'b0;
        chk("pre_rst_valid", 32'(o_valid), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(o_valid), 32'h0);
        chk("async_data", 32'(o_data), 32'h0);
`ifdef ONEHOT_DEMUX_CHECK_EN
        chk("async_err", 32'(o_err), 32'h0);
`endif
        q[0].delete();
        q[1].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        o_ready = 2'b11;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
